// File: rtl/axil_membus_pkg.sv
// axil_membus_pkg: state encoding and response codes shared by the AXI4-Lite to memory-bus bridge
package axil_membus_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE    = 3'd0;
    localparam state_t WR_STB  = 3'd1;
    localparam state_t WR_WAIT = 3'd2;
    localparam state_t WR_RESP = 3'd3;
    localparam state_t RD_STB  = 3'd4;
    localparam state_t RD_WAIT = 3'd5;
    localparam state_t RD_RESP = 3'd6;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [31:0] DEAD_RDATA = 32'h0;
endpackage

// File: rtl/axil_membus_timeout.sv
// axil_membus_timeout: loadable down-counter bounding how long the bridge waits for done
module axil_membus_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) cnt <= '0;
        else if (load) cnt <= W'(TIMEOUT);
        else if (enable && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = cnt == '0;
endmodule

// File: rtl/axil_membus_bridge.sv
// axil_membus_bridge: AXI4-Lite slave driving a single-strobe Rd/Wr memory bus, one access at a time
module axil_membus_bridge
    import axil_membus_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ADDR_W-3:0] m_addr,
    output logic [31:0]       m_wr_data,
    output logic              m_rd_mem,
    output logic              m_wr_mem,
    input  logic [31:0]       m_rd_data,
    input  logic              m_rd_done,
    input  logic              m_wr_done,
    input  logic              m_rd_error,
    input  logic              m_wr_error
);
    state_t state, next;
    logic aw_held, w_held, ar_held, last_wr, expired;
    logic [ADDR_W-3:0] aw_addr, ar_addr;
    logic [31:0] w_data;
    logic [3:0] w_strb;
    logic unused_bits;
    assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0]};
    wire aw_hs = s_awvalid && s_awready;
    wire w_hs = s_wvalid && s_wready;
    wire ar_hs = s_arvalid && s_arready;
    wire aw_n = aw_held || aw_hs;
    wire w_n = w_held || w_hs;
    wire ar_n = ar_held || ar_hs;
    wire idle = state == IDLE;
    // On a collision the side not served last goes first
    wire pick_wr = idle && aw_n && w_n && (!ar_n || !last_wr);
    wire pick_rd = idle && ar_n && !pick_wr;
    wire [ADDR_W-3:0] a_w = aw_held ? aw_addr : s_awaddr[ADDR_W-1:2];
    wire [ADDR_W-3:0] a_r = ar_held ? ar_addr : s_araddr[ADDR_W-1:2];
    wire [31:0] d_w = w_held ? w_data : s_wdata;
    wire strb_ok = (w_held ? w_strb : s_wstrb) == 4'hF;
    wire aw_held_n = aw_n && !pick_wr;
    wire w_held_n = w_n && !pick_wr;
    wire ar_held_n = ar_n && !pick_rd;
    wire wr_end = state == WR_WAIT && (m_wr_done || expired);
    wire rd_end = state == RD_WAIT && (m_rd_done || expired);
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = pick_wr ? (strb_ok ? WR_STB : WR_RESP) : pick_rd ? RD_STB : IDLE;
            WR_STB:  next = WR_WAIT;
            WR_WAIT: next = wr_end ? WR_RESP : WR_WAIT;
            WR_RESP: next = s_bready ? IDLE : WR_RESP;
            RD_STB:  next = RD_WAIT;
            RD_WAIT: next = rd_end ? RD_RESP : RD_WAIT;
            RD_RESP: next = s_rready ? IDLE : RD_RESP;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            {aw_held, w_held, ar_held} <= '0;
            {s_awready, s_wready, s_arready} <= '0;
            last_wr <= 1'b1;
            aw_addr <= '0;
            ar_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            m_addr <= '0;
            m_wr_data <= '0;
            s_bresp <= RESP_OKAY;
            s_rresp <= RESP_OKAY;
            s_rdata <= '0;
        end else begin
            state <= next;
            aw_held <= aw_held_n;
            w_held <= w_held_n;
            ar_held <= ar_held_n;
            s_awready <= next == IDLE && !aw_held_n;
            s_wready <= next == IDLE && !w_held_n;
            s_arready <= next == IDLE && !ar_held_n;
            if (aw_hs) aw_addr <= s_awaddr[ADDR_W-1:2];
            if (ar_hs) ar_addr <= s_araddr[ADDR_W-1:2];
            if (w_hs) begin
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end
            if (pick_wr) begin
                last_wr <= 1'b1;
                s_bresp <= strb_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (pick_wr && strb_ok) begin
                m_addr <= a_w;
                m_wr_data <= d_w;
            end
            if (pick_rd) begin
                last_wr <= 1'b0;
                m_addr <= a_r;
            end
            if (wr_end) s_bresp <= (m_wr_done && !m_wr_error) ? RESP_OKAY : RESP_SLVERR;
            if (rd_end) begin
                s_rresp <= (m_rd_done && !m_rd_error) ? RESP_OKAY : RESP_SLVERR;
                s_rdata <= m_rd_done ? m_rd_data : DEAD_RDATA;
            end
        end
    end
    assign s_bvalid = state == WR_RESP;
    assign s_rvalid = state == RD_RESP;
    assign m_wr_mem = state == WR_STB;
    assign m_rd_mem = state == RD_STB;
    axil_membus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk(clk),
        .rst_n(rst_n),
        .clear(idle),
        .load(state == WR_STB || state == RD_STB),
        .enable(state == WR_WAIT || state == RD_WAIT),
        .expired(expired)
    );
endmodule
